// File: rtl/up_bus_master.sv
`timescale 1ns/1ps
// Initiator for the up_ register bus: one command in, one req/ack exchange, one response out.
// Define UP_BUS_MASTER_TIMEOUT_EN to enable the ack timeout (error response with ERR_RDATA).
module up_bus_master #(
    parameter int          ADDR_WIDTH     = 14,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_RDATA      = 32'hDEAD_DEAD
) (
    input  logic                  up_clk,
    input  logic                  up_rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_rnw,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [31:0]           cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic                  up_wreq,
    output logic [ADDR_WIDTH-1:0] up_waddr,
    output logic [31:0]           up_wdata,
    input  logic                  up_wack,
    output logic                  up_rreq,
    output logic [ADDR_WIDTH-1:0] up_raddr,
    input  logic [31:0]           up_rdata,
    input  logic                  up_rack
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    logic [1:0]            state_reg;
    logic                  rnw_reg;
    logic                  cmd_ready_reg;
    logic                  rsp_valid_reg;
    logic [31:0]           rsp_rdata_reg;
    logic                  up_wreq_reg;
    logic                  up_rreq_reg;
    logic [ADDR_WIDTH-1:0] up_waddr_reg;
    logic [ADDR_WIDTH-1:0] up_raddr_reg;
    logic [31:0]           up_wdata_reg;
    logic                  ack_match;
    logic                  timeout_hit;

    // Only the ack belonging to the outstanding request type is honoured.
    assign ack_match = rnw_reg ? up_rack : up_wack;

`ifdef UP_BUS_MASTER_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] timeout_cnt_reg;
    logic        rsp_err_reg;

    assign timeout_hit = (state_reg == ST_WAIT) && !ack_match && (timeout_cnt_reg == TIMEOUT_LAST);

    always_ff @(posedge up_clk) begin
        if (up_rst) begin
            timeout_cnt_reg <= 16'd0;
            rsp_err_reg     <= 1'b0;
        end else begin
            if (state_reg == ST_REQ) begin
                timeout_cnt_reg <= 16'd0;
            end else if ((state_reg == ST_WAIT) && !ack_match) begin
                timeout_cnt_reg <= timeout_cnt_reg + 16'd1;
            end
            // An ack in the expiry cycle wins over the timeout.
            if (state_reg == ST_WAIT) begin
                if (ack_match) begin
                    rsp_err_reg <= 1'b0;
                end else if (timeout_hit) begin
                    rsp_err_reg <= 1'b1;
                end
            end
        end
    end

    assign rsp_err = rsp_err_reg;
`else
    logic unused_cfg;

    assign timeout_hit = 1'b0;
    assign rsp_err     = 1'b0;
    assign unused_cfg  = ^{ERR_RDATA, TIMEOUT_CYCLES};
`endif

    always_ff @(posedge up_clk) begin
        if (up_rst) begin
            state_reg     <= ST_IDLE;
            rnw_reg       <= 1'b0;
            cmd_ready_reg <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= 32'd0;
            up_wreq_reg   <= 1'b0;
            up_rreq_reg   <= 1'b0;
            up_waddr_reg  <= '0;
            up_raddr_reg  <= '0;
            up_wdata_reg  <= 32'd0;
        end else begin
            up_wreq_reg <= 1'b0;
            up_rreq_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    cmd_ready_reg <= 1'b1;
                    if (cmd_valid && cmd_ready_reg) begin
                        cmd_ready_reg <= 1'b0;
                        rnw_reg       <= cmd_rnw;
                        state_reg     <= ST_REQ;
                        if (cmd_rnw) begin
                            up_rreq_reg  <= 1'b1;
                            up_raddr_reg <= cmd_addr;
                        end else begin
                            up_wreq_reg  <= 1'b1;
                            up_waddr_reg <= cmd_addr;
                            up_wdata_reg <= cmd_wdata;
                        end
                    end
                end
                ST_REQ: begin
                    state_reg <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (ack_match) begin
                        rsp_valid_reg <= 1'b1;
                        rsp_rdata_reg <= rnw_reg ? up_rdata : 32'd0;
                        state_reg     <= ST_RESP;
                    end else if (timeout_hit) begin
                        rsp_valid_reg <= 1'b1;
                        rsp_rdata_reg <= ERR_RDATA;
                        state_reg     <= ST_RESP;
                    end
                end
                default: begin
                    if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        cmd_ready_reg <= 1'b1;
                        state_reg     <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign cmd_ready = cmd_ready_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_rdata = rsp_rdata_reg;
    assign up_wreq   = up_wreq_reg;
    assign up_rreq   = up_rreq_reg;
    assign up_waddr  = up_waddr_reg;
    assign up_raddr  = up_raddr_reg;
    assign up_wdata  = up_wdata_reg;

endmodule

// File: tb/tb_up_bus_master.sv
`timescale 1ns/1ps
// Randomised self-checking bench for up_bus_master with a register-bank responder
// and a command-history model of expected read data, latency and error status.
module tb_up_bus_master;

    localparam int          AW  = 14;
    localparam int          TO  = 8;
    localparam logic [31:0] ERR = 32'hDEAD_DEAD;
`ifdef UP_BUS_MASTER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          up_clk;
    logic          up_rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_rnw;
    logic [AW-1:0] cmd_addr;
    logic [31:0]   cmd_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic          up_wreq;
    logic [AW-1:0] up_waddr;
    logic [31:0]   up_wdata;
    logic          up_wack;
    logic          up_rreq;
    logic [AW-1:0] up_raddr;
    logic [31:0]   up_rdata;
    logic          up_rack;

    up_bus_master #(
        .ADDR_WIDTH    (AW),
        .TIMEOUT_CYCLES(TO),
        .ERR_RDATA     (ERR)
    ) dut (
        .up_clk   (up_clk),
        .up_rst   (up_rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_rnw  (cmd_rnw),
        .cmd_addr (cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .up_wreq  (up_wreq),
        .up_waddr (up_waddr),
        .up_wdata (up_wdata),
        .up_wack  (up_wack),
        .up_rreq  (up_rreq),
        .up_raddr (up_raddr),
        .up_rdata (up_rdata),
        .up_rack  (up_rack)
    );

    initial up_clk = 1'b0;
    always #5 up_clk = ~up_clk;

    int passed;
    int total;
    int cyc;

    // Responder register bank (written by observed bus writes) and the expected contents (from commands).
    logic [31:0] regs   [0:16383];
    logic [31:0] shadow [0:16383];

    int          obs_wait, obs_accept_cyc, obs_req_k, obs_wpulses, obs_rpulses, obs_rsp_k;
    bit          obs_both, obs_unstable, obs_ready_hi, obs_stuck;
    logic [AW-1:0] obs_addr;
    logic [31:0] obs_wdata, obs_rdata;
    logic        obs_err;

    task automatic step();
        @(posedge up_clk);
        #1;
        cyc++;
    endtask

    // Runs one command through the DUT. ack_dly<=0 means the responder never acks;
    // stray_k pulses the non-matching ack and late_k an extra matching ack at that cycle offset.
    task automatic run_txn(input logic rnw, input logic [AW-1:0] addr, input logic [31:0] wdata,
                           input int ack_dly, input int rdy_dly, input int stray_k, input int late_k,
                           input bit hold);
        int k;
        int rsp_cnt;
        bit done;
        obs_req_k = -1; obs_rsp_k = -1; obs_wpulses = 0; obs_rpulses = 0;
        obs_both = 0; obs_unstable = 0; obs_ready_hi = 0;
        obs_addr = '0; obs_wdata = 32'd0; obs_rdata = 32'd0; obs_err = 1'b0;
        cmd_valid = 1'b1; cmd_rnw = rnw; cmd_addr = addr; cmd_wdata = wdata;
        obs_wait = 0;
        while (cmd_ready !== 1'b1 && obs_wait < 50) begin
            step();
            obs_wait++;
        end
        obs_accept_cyc = cyc;
        step();
        cmd_valid = hold;
        k = 1; done = 0; rsp_cnt = 0;
        while (!done && k < 200) begin
            if (up_wreq === 1'b1 && up_rreq === 1'b1) obs_both = 1;
            if (up_wreq === 1'b1) begin
                obs_wpulses++;
                if (obs_req_k < 0) begin obs_req_k = k; obs_addr = up_waddr; obs_wdata = up_wdata; end
                regs[up_waddr] = up_wdata;
            end
            if (up_rreq === 1'b1) begin
                obs_rpulses++;
                if (obs_req_k < 0) begin obs_req_k = k; obs_addr = up_raddr; end
            end
            if (cmd_ready === 1'b1) obs_ready_hi = 1;
            up_wack = 1'b0; up_rack = 1'b0; up_rdata = $urandom;
            if ((ack_dly > 0 && obs_req_k >= 0 && k == obs_req_k + ack_dly) || k == late_k) begin
                if (rnw) begin up_rack = 1'b1; up_rdata = regs[up_raddr]; end
                else up_wack = 1'b1;
            end
            if (k == stray_k) begin
                if (rnw) up_wack = 1'b1;
                else up_rack = 1'b1;
            end
            rsp_ready = 1'b0;
            if (rsp_valid === 1'b1) begin
                if (obs_rsp_k < 0) begin obs_rsp_k = k; obs_rdata = rsp_rdata; obs_err = rsp_err; end
                else if (rsp_rdata !== obs_rdata || rsp_err !== obs_err) obs_unstable = 1;
                if (rsp_cnt == rdy_dly) begin rsp_ready = 1'b1; done = 1; end
                rsp_cnt++;
            end
            step();
            k++;
        end
        rsp_ready = 1'b0; up_wack = 1'b0; up_rack = 1'b0;
        obs_stuck = !done || obs_wait >= 50;
        total++;
        if (obs_stuck) $display("FAIL txn_complete got stuck=1 want 0 (wait=%0d k=%0d)", obs_wait, k);
        else passed++;
        $display("txn rnw=%0d addr=%h wdata=%h ack_dly=%0d rdy_dly=%0d -> rsp_k=%0d rdata=%h err=%0d",
                 rnw, addr, wdata, ack_dly, rdy_dly, obs_rsp_k, obs_rdata, obs_err);
    endtask

    task automatic test_reset();
        up_rst = 1'b1; cmd_valid = 1'b0; cmd_rnw = 1'b0; cmd_addr = '0; cmd_wdata = 32'd0;
        rsp_ready = 1'b0; up_wack = 1'b0; up_rack = 1'b0; up_rdata = 32'd0;
        repeat (3) step();
        total++;
        if ({cmd_ready, rsp_valid, rsp_rdata, rsp_err, up_wreq, up_rreq, up_waddr, up_raddr, up_wdata} !== '0)
            $display("FAIL reset_outputs got cmd_ready=%b rsp_valid=%b rdata=%h err=%b wreq=%b rreq=%b want all 0",
                     cmd_ready, rsp_valid, rsp_rdata, rsp_err, up_wreq, up_rreq);
        else passed++;
        up_rst = 1'b0;
        step();
        total++;
        if (cmd_ready !== 1'b1) $display("FAIL reset_release_ready got %b want 1", cmd_ready); else passed++;
        total++;
        if (rsp_valid !== 1'b0) $display("FAIL reset_release_rsp got %b want 0", rsp_valid); else passed++;
    endtask

    task automatic test_write();
        shadow[14'h0040] = 32'h0000_0003;
        run_txn(1'b0, 14'h0040, 32'h0000_0003, 2, 0, -1, -1, 0);
        total++; if (obs_req_k !== 1) $display("FAIL write_req_cycle got %0d want 1", obs_req_k); else passed++;
        total++; if (obs_wpulses !== 1 || obs_rpulses !== 0)
            $display("FAIL write_pulses got w=%0d r=%0d want w=1 r=0", obs_wpulses, obs_rpulses); else passed++;
        total++; if (obs_addr !== 14'h0040) $display("FAIL write_addr got %h want 0040", obs_addr); else passed++;
        total++; if (obs_wdata !== 32'h3) $display("FAIL write_data got %h want 00000003", obs_wdata); else passed++;
        total++; if (obs_rsp_k !== 4) $display("FAIL write_latency got %0d want 4", obs_rsp_k); else passed++;
        total++; if (obs_rdata !== 32'd0 || obs_err !== 1'b0)
            $display("FAIL write_rsp got rdata=%h err=%b want 0/0", obs_rdata, obs_err); else passed++;
        total++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0)
            $display("FAIL write_return_idle got ready=%b valid=%b want 1/0", cmd_ready, rsp_valid); else passed++;
    endtask

    task automatic test_read();
        shadow[14'h0102] = 32'h1234_5678;
        run_txn(1'b0, 14'h0102, 32'h1234_5678, 1, 0, -1, -1, 0);
        run_txn(1'b1, 14'h0102, 32'h0, 1, 0, -1, -1, 0);
        total++; if (obs_rpulses !== 1 || obs_wpulses !== 0)
            $display("FAIL read_pulses got r=%0d w=%0d want r=1 w=0", obs_rpulses, obs_wpulses); else passed++;
        total++; if (obs_addr !== 14'h0102) $display("FAIL read_addr got %h want 0102", obs_addr); else passed++;
        total++; if (obs_rsp_k !== 3) $display("FAIL read_latency got %0d want 3", obs_rsp_k); else passed++;
        total++; if (obs_rdata !== shadow[14'h0102] || obs_err !== 1'b0)
            $display("FAIL read_rsp got rdata=%h err=%b want %h/0", obs_rdata, obs_err, shadow[14'h0102]); else passed++;
    endtask

    task automatic test_backpressure();
        run_txn(1'b1, 14'h0102, 32'h0, 2, 10, -1, -1, 1);
        total++; if (obs_unstable !== 1'b0) $display("FAIL bp_stable got unstable=1 want 0"); else passed++;
        total++; if (obs_ready_hi !== 1'b0) $display("FAIL bp_cmd_ready got high=1 want 0"); else passed++;
        total++; if (obs_rdata !== shadow[14'h0102])
            $display("FAIL bp_rdata got %h want %h", obs_rdata, shadow[14'h0102]); else passed++;
        run_txn(1'b1, 14'h0102, 32'h0, 1, 0, -1, -1, 0);
        total++; if (obs_wait !== 0) $display("FAIL bp_next_accept got wait=%0d want 0", obs_wait); else passed++;
        total++; if (obs_rdata !== shadow[14'h0102] || obs_rsp_k !== 3)
            $display("FAIL bp_next_rsp got rdata=%h k=%0d want %h/3", obs_rdata, obs_rsp_k, shadow[14'h0102]); else passed++;
    endtask

    task automatic test_stray_acks();
        logic [31:0] wd;
        up_wack = 1'b1; up_rack = 1'b1; up_rdata = 32'hBAD0_BAD0;
        step();
        up_wack = 1'b0; up_rack = 1'b0;
        step();
        total++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0)
            $display("FAIL stray_idle got ready=%b valid=%b want 1/0", cmd_ready, rsp_valid); else passed++;
        wd = $urandom;
        shadow[14'h0055] = wd;
        run_txn(1'b0, 14'h0055, wd, 4, 0, 2, -1, 0);
        total++; if (obs_rsp_k !== 6) $display("FAIL stray_write_latency got %0d want 6", obs_rsp_k); else passed++;
        total++; if (obs_rdata !== 32'd0 || obs_err !== 1'b0)
            $display("FAIL stray_write_rsp got rdata=%h err=%b want 0/0", obs_rdata, obs_err); else passed++;
        run_txn(1'b1, 14'h0055, 32'h0, 3, 0, 2, -1, 0);
        total++; if (obs_rsp_k !== 5 || obs_rdata !== wd)
            $display("FAIL stray_read got k=%0d rdata=%h want 5/%h", obs_rsp_k, obs_rdata, wd); else passed++;
    endtask

    task automatic test_wait_bound();
`ifdef UP_BUS_MASTER_TIMEOUT_EN
        run_txn(1'b1, 14'h0200, 32'h0, -1, 2, -1, 10, 0);
        total++; if (obs_rsp_k !== TO + 2) $display("FAIL timeout_latency got %0d want %0d", obs_rsp_k, TO + 2); else passed++;
        total++; if (obs_err !== 1'b1 || obs_rdata !== ERR)
            $display("FAIL timeout_rsp got rdata=%h err=%b want %h/1", obs_rdata, obs_err, ERR); else passed++;
        total++; if (obs_unstable !== 1'b0) $display("FAIL timeout_late_ack got unstable=1 want 0"); else passed++;
        up_rack = 1'b1;
        step();
        up_rack = 1'b0;
        step();
        total++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0)
            $display("FAIL timeout_late_idle got ready=%b valid=%b want 1/0", cmd_ready, rsp_valid); else passed++;
        run_txn(1'b1, 14'h0102, 32'h0, TO, 0, -1, -1, 0);
        total++; if (obs_err !== 1'b0 || obs_rsp_k !== TO + 2 || obs_rdata !== shadow[14'h0102])
            $display("FAIL timeout_ack_last got err=%b k=%0d rdata=%h want 0/%0d/%h",
                     obs_err, obs_rsp_k, obs_rdata, TO + 2, shadow[14'h0102]); else passed++;
`else
        run_txn(1'b1, 14'h0102, 32'h0, 30, 0, -1, -1, 0);
        total++; if (obs_rsp_k !== 32 || obs_err !== 1'b0 || obs_rdata !== shadow[14'h0102])
            $display("FAIL long_wait got k=%0d err=%b rdata=%h want 32/0/%h",
                     obs_rsp_k, obs_err, obs_rdata, shadow[14'h0102]); else passed++;
`endif
    endtask

    task automatic test_back_to_back();
        int prev;
        run_txn(1'b1, 14'h0040, 32'h0, 1, 0, -1, -1, 0);
        for (int i = 0; i < 3; i++) begin
            prev = obs_accept_cyc;
            run_txn(i[0], 14'(i + 1), 32'(i * 7 + 1), 1, 0, -1, -1, 0);
            if (!i[0]) shadow[14'(i + 1)] = 32'(i * 7 + 1);
            total++; if (obs_accept_cyc - prev !== 4)
                $display("FAIL b2b_period got %0d want 4", obs_accept_cyc - prev); else passed++;
        end
    endtask

    task automatic test_random();
        logic          rnw;
        logic [AW-1:0] addr;
        logic [31:0]   wd, exp_rdata;
        int            ad, rd, exp_k;
        bit            timed;
        for (int i = 0; i < 40; i++) begin
            rnw  = 1'($urandom_range(0, 1));
            addr = 14'($urandom_range(0, 15));
            wd   = $urandom;
            ad   = $urandom_range(1, 10);
            rd   = $urandom_range(0, 3);
            timed = TO_EN && (ad > TO);
            exp_k = timed ? TO + 2 : ad + 2;
            if (!rnw) shadow[addr] = wd;
            exp_rdata = timed ? ERR : (rnw ? shadow[addr] : 32'd0);
            run_txn(rnw, addr, wd, ad, rd, -1, -1, 0);
            total++; if (obs_addr !== addr || (!rnw && obs_wdata !== wd))
                $display("FAIL rand_bus got addr=%h wdata=%h want %h/%h", obs_addr, obs_wdata, addr, wd); else passed++;
            total++; if (obs_both || obs_wpulses !== (rnw ? 0 : 1) || obs_rpulses !== (rnw ? 1 : 0))
                $display("FAIL rand_pulses got w=%0d r=%0d both=%0d want rnw=%0d", obs_wpulses, obs_rpulses, obs_both, rnw); else passed++;
            total++; if (obs_rsp_k !== exp_k) $display("FAIL rand_latency got %0d want %0d", obs_rsp_k, exp_k); else passed++;
            total++; if (obs_rdata !== exp_rdata || obs_err !== timed)
                $display("FAIL rand_rsp got rdata=%h err=%b want %h/%b", obs_rdata, obs_err, exp_rdata, timed); else passed++;
        end
    endtask

    task automatic test_reset_mid_wait();
        bit seen;
        cmd_valid = 1'b1; cmd_rnw = 1'b1; cmd_addr = 14'h0003; cmd_wdata = 32'd0;
        for (int i = 0; i < 20 && cmd_ready !== 1'b1; i++) step();
        step();
        cmd_valid = 1'b0;
        step();
        up_rst = 1'b1;
        step();
        total++;
        if ({cmd_ready, rsp_valid, rsp_rdata, rsp_err, up_wreq, up_rreq, up_waddr, up_raddr, up_wdata} !== '0)
            $display("FAIL midreset_outputs got ready=%b valid=%b rdata=%h raddr=%h want all 0",
                     cmd_ready, rsp_valid, rsp_rdata, up_raddr);
        else passed++;
        up_rst = 1'b0; up_rack = 1'b1; up_rdata = 32'h5555_AAAA;
        step();
        up_rack = 1'b0;
        total++; if (cmd_ready !== 1'b1) $display("FAIL midreset_ready got %b want 1", cmd_ready); else passed++;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (rsp_valid !== 1'b0) seen = 1;
            step();
        end
        total++; if (seen) $display("FAIL midreset_no_rsp got rsp_valid=1 want 0"); else passed++;
    endtask

    initial begin
        passed = 0; total = 0; cyc = 0;
        for (int i = 0; i < 16384; i++) begin
            regs[i] = 32'd0;
            shadow[i] = 32'd0;
        end
        test_reset();
        test_write();
        test_read();
        test_backpressure();
        test_stray_acks();
        test_wait_bound();
        test_back_to_back();
        test_random();
        test_reset_mid_wait();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got no finish want finish within 1ms");
        $fatal(1, "watchdog expired");
    end

endmodule
